uart_receiver: RTL and testbench

Receive half of the UART. Takes the serial line `rxd`, oversamples it with the baud-rate generator enable, and reassembles 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1). The byte goes to a holding register with a data-available flag, a framing-error flag and an overrun flag for the bus interface. It pairs with the transmitter on the same BRG. The BRG is configured so that `baud_enable` to this block pulses OVERSAMPLE times per bit.

---
 rtl/uart_receiver_if.sv | 22 ++
 rtl/uart_receiver.sv | 199 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// uart_receiver_if -- bus-side handshake of the UART receiver.
//
// Signals:
//   rd_ack  one-cycle pulse from the bus: it has read data
//   data    last received byte
//   rda     receive data available
//   ferr    framing error of the last loaded frame
//   oerr    overrun: a frame was loaded while rda was still set
//
// Modports:
//   master  bus side (drives rd_ack, observes the status/data)
//   slave   receiver side (observes rd_ack, drives the status/data)
interface uart_receiver_if;
  logic       rd_ack;
  logic [7:0] data;
  logic       rda;
  logic       ferr;
  logic       oerr;

  modport master (output rd_ack, input data, rda, ferr, oerr);
  modport slave  (input rd_ack, output data, rda, ferr, oerr);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver -- receive half of the UART (8N1, LSB first).
//
// The serial line is synchronised, then sampled on baud_enable ticks that
// arrive OVERSAMPLE times per bit. A completed frame is loaded into a
// holding register with data-available, framing-error and overrun flags.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   baud_enable  one-cycle tick at OVERSAMPLE x bit rate
//   rxd          serial input (asynchronous, idles high)
//   bus          uart_receiver_if.slave: rd_ack in; data, rda, ferr, oerr out
//
// Optional build macro:
//   RX_MAJORITY_VOTE_EN  each sample becomes the 2-of-3 majority of rxd_s
//                        seen at ticks N-2, N-1 and N of the sample point.
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_enable,
  input  logic           rxd,
  uart_receiver_if.slave bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    data_reg, data_next;
  logic          rda_reg, rda_next;
  logic          ferr_reg, ferr_next;
  logic          oerr_reg, oerr_next;
  logic          break_reg, break_next;
  logic          rxd_meta_reg, rxd_s_reg;
  logic          sample;
  logic          load;

  // Two-flop synchronizer; both flops reset to the idle (high) level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_reg <= 1'b1;
      rxd_s_reg    <= 1'b1;
    end else begin
      rxd_meta_reg <= rxd;
      rxd_s_reg    <= rxd_meta_reg;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  // hist_reg[0] holds rxd_s from the previous tick, hist_reg[1] from the one
  // before. The counters advance every tick, so at sample tick N these are the
  // values from N-1 and N-2.
  logic [1:0] hist_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg <= 2'b11;
    end else if (baud_enable) begin
      hist_reg <= {hist_reg[0], rxd_s_reg};
    end
  end

  assign sample = (hist_reg[1] & hist_reg[0]) |
                  (hist_reg[1] & rxd_s_reg)   |
                  (hist_reg[0] & rxd_s_reg);
`else
  assign sample = rxd_s_reg;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      rda_reg      <= 1'b0;
      ferr_reg     <= 1'b0;
      oerr_reg     <= 1'b0;
      break_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      data_reg     <= data_next;
      rda_reg      <= rda_next;
      ferr_reg     <= ferr_next;
      oerr_reg     <= oerr_next;
      break_reg    <= break_next;
    end
  end

  // Frame sequencing. Nothing moves without a baud tick, so all state holds
  // between ticks, including mid-frame.
  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    break_next    = break_reg;
    load          = 1'b0;

    if (baud_enable) begin
      case (state_reg)
        IDLE: begin
          // After a frame whose stop bit read low (e.g. a line break), wait
          // for the line to return high so a held-low line loads only once.
          if (break_reg) begin
            if (rxd_s_reg) begin
              break_next = 1'b0;
            end
          end else if (!rxd_s_reg) begin
            state_next    = START;
            tick_cnt_next = '0;
          end
        end

        START: begin
          if (tick_cnt_reg == HALF_LAST) begin
            tick_cnt_next = '0;
            if (!sample) begin
              state_next   = DATA;
              bit_cnt_next = '0;
            end else begin
              state_next = IDLE;  // false start, no flag changes
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end

        DATA: begin
          if (tick_cnt_reg == BIT_LAST) begin
            shift_next    = {sample, shift_reg[7:1]};  // LSB arrives first
            tick_cnt_next = '0;
            bit_cnt_next  = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_next = STOP;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end

        STOP: begin
          if (tick_cnt_reg == BIT_LAST) begin
            load          = 1'b1;
            tick_cnt_next = '0;
            state_next    = IDLE;
            if (!sample) begin
              break_next = 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TW'(1);
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  // Holding register and flags. A load on the same edge as rd_ack wins:
  // rda stays set and the ack does not count as an overrun.
  always_comb begin
    data_next = data_reg;
    rda_next  = rda_reg;
    ferr_next = ferr_reg;
    oerr_next = oerr_reg;

    if (load) begin
      data_next = shift_reg;
      rda_next  = 1'b1;
      ferr_next = ~sample;
      if (rda_reg && !bus.rd_ack) begin
        oerr_next = 1'b1;
      end
    end else if (bus.rd_ack && rda_reg) begin
      rda_next  = 1'b0;
      oerr_next = 1'b0;
    end
  end

  assign bus.data = data_reg;
  assign bus.rda  = rda_reg;
  assign bus.ferr = ferr_reg;
  assign bus.oerr = oerr_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver -- self-checking bench for uart_receiver.
// Frames are driven bit by bit on baud ticks (OVERSAMPLE=16, a tick every
// 4 clk); the expected holding register and flags come from a small model of
// the receiver's bus-visible behaviour.
module tb_uart_receiver;

  localparam int BAUD_DIV = 4;
  localparam int OS       = 16;
  localparam int FULL     = 161;      // ticks to drive a whole frame plus idle edge
  localparam int LOAD_TK  = OS / 2 + 9 * OS + 1;  // tick index of load, relative to falling edge

  logic clk;
  logic rst;
  logic baud_enable;
  logic rxd;
  int   phase;

  uart_receiver_if bus ();

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_enable (baud_enable),
    .rxd         (rxd),
    .bus         (bus.slave)
  );

  int vectors;
  int miscompares;

  // Bus-visible model of the receiver.
  logic [7:0] m_data;
  logic       m_rda, m_ferr, m_oerr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_enable = 1'b0;
    phase       = 0;
    forever begin
      @(negedge clk);
      baud_enable = (phase == BAUD_DIV - 1);
      phase       = (phase + 1) % BAUD_DIV;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  // Returns 1 ns after the next clock edge that carries a baud tick.
  task automatic wait_tick();
    @(posedge clk);
    while (!baud_enable) @(posedge clk);
    #1;
  endtask

  function automatic logic line_level(input logic [7:0] b, input logic stop, input int i);
    int seg;
    seg = i / OS;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return b[seg-1];
    if (seg == 9) return stop;
    return 1'b1;
  endfunction

  // Drives one frame. Tick 0 is the tick after which the start bit begins.
  // ack_tick: tick on whose edge rd_ack is high (0 = none).
  // glitch_tick: tick at which rxd_s shows a one-tick 0 (0 = none).
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int ack_tick,
                             input int glitch_tick, input int max_ticks, output int rda_tick);
    logic prev_rda;
    rda_tick = -1;
    wait_tick();
    prev_rda = bus.rda;
    for (int i = 0; i < max_ticks; i++) begin
      rxd = line_level(b, stop, i);
      if (glitch_tick != 0 && i == glitch_tick - 1) rxd = 1'b0;
      if (ack_tick == i + 1) begin
        repeat (BAUD_DIV - 1) @(posedge clk);
        #1 bus.rd_ack = 1'b1;
      end
      wait_tick();
      bus.rd_ack = 1'b0;
      if (rda_tick < 0 && !prev_rda && bus.rda) rda_tick = i + 1;
      prev_rda = bus.rda;
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
    if (m_rda) begin
      m_rda  = 1'b0;
      m_oerr = 1'b0;
    end
  endtask

  function automatic void model_load(input logic [7:0] b, input logic stop, input logic ack);
    if (m_rda && !ack) m_oerr = 1'b1;
    m_data = b;
    m_rda  = 1'b1;
    m_ferr = ~stop;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (bus.data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", bus.data); end
    vectors++; if (bus.rda !== 1'b0) begin miscompares++; $display("FAIL reset_rda got %b want 0", bus.rda); end
    vectors++; if (bus.ferr !== 1'b0) begin miscompares++; $display("FAIL reset_ferr got %b want 0", bus.ferr); end
    vectors++; if (bus.oerr !== 1'b0) begin miscompares++; $display("FAIL reset_oerr got %b want 0", bus.oerr); end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) wait_tick();
    $display("reset: outputs cleared while held, released");
  endtask

  task automatic test_nominal();
    int t;
    drive_frame(8'hA5, 1'b1, 0, 0, FULL, t);
    model_load(8'hA5, 1'b1, 1'b0);
    vectors++; if (t !== LOAD_TK) begin miscompares++; $display("FAIL nominal_latency got %0d want %0d ticks", t, LOAD_TK); end
    vectors++; if (bus.data !== m_data) begin miscompares++; $display("FAIL nominal_data got %h want %h", bus.data, m_data); end
    vectors++; if (bus.rda !== m_rda) begin miscompares++; $display("FAIL nominal_rda got %b want %b", bus.rda, m_rda); end
    vectors++; if (bus.ferr !== m_ferr) begin miscompares++; $display("FAIL nominal_ferr got %b want %b", bus.ferr, m_ferr); end
    vectors++; if (bus.oerr !== m_oerr) begin miscompares++; $display("FAIL nominal_oerr got %b want %b", bus.oerr, m_oerr); end
    $display("nominal: byte A5 rda after %0d ticks data=%h", t, bus.data);
    pulse_ack();
    vectors++; if (bus.rda !== m_rda) begin miscompares++; $display("FAIL nominal_ack_rda got %b want %b", bus.rda, m_rda); end
  endtask

  task automatic test_false_start();
    int t;
    logic [7:0] b;
    wait_tick();
    rxd = 1'b0;
    repeat (4) wait_tick();
    rxd = 1'b1;
    repeat (200) wait_tick();
    vectors++; if (bus.rda !== 1'b0) begin miscompares++; $display("FAIL false_start_rda got %b want 0", bus.rda); end
    b = 8'($urandom_range(0, 255));
    drive_frame(b, 1'b1, 0, 0, FULL, t);
    model_load(b, 1'b1, 1'b0);
    vectors++; if (bus.data !== m_data) begin miscompares++; $display("FAIL false_start_next_data got %h want %h", bus.data, m_data); end
    vectors++; if (bus.rda !== m_rda) begin miscompares++; $display("FAIL false_start_next_rda got %b want %b", bus.rda, m_rda); end
    $display("false_start: 4-tick low ignored, next byte %h data=%h", b, bus.data);
    pulse_ack();
  endtask

  task automatic test_framing();
    int t;
    drive_frame(8'h3C, 1'b0, 0, 0, FULL, t);
    model_load(8'h3C, 1'b0, 1'b0);
    vectors++; if (bus.data !== m_data) begin miscompares++; $display("FAIL framing_data got %h want %h", bus.data, m_data); end
    vectors++; if (bus.rda !== m_rda) begin miscompares++; $display("FAIL framing_rda got %b want %b", bus.rda, m_rda); end
    vectors++; if (bus.ferr !== m_ferr) begin miscompares++; $display("FAIL framing_ferr got %b want %b", bus.ferr, m_ferr); end
    $display("framing: byte 3C bad stop ferr=%b", bus.ferr);
    drive_frame(8'h01, 1'b1, 0, 0, FULL, t);
    model_load(8'h01, 1'b1, 1'b0);
    vectors++; if (bus.data !== m_data) begin miscompares++; $display("FAIL framing_next_data got %h want %h", bus.data, m_data); end
    vectors++; if (bus.ferr !== m_ferr) begin miscompares++; $display("FAIL framing_next_ferr got %b want %b", bus.ferr, m_ferr); end
    vectors++; if (bus.oerr !== m_oerr) begin miscompares++; $display("FAIL framing_next_oerr got %b want %b", bus.oerr, m_oerr); end
    $display("framing: byte 01 good stop ferr=%b", bus.ferr);
    pulse_ack();
  endtask

  task automatic test_overrun();
    int t;
    drive_frame(8'h11, 1'b1, 0, 0, FULL, t);
    model_load(8'h11, 1'b1, 1'b0);
    drive_frame(8'h22, 1'b1, 0, 0, FULL, t);
    model_load(8'h22, 1'b1, 1'b0);
    vectors++; if (bus.data !== m_data) begin miscompares++; $display("FAIL overrun_data got %h want %h", bus.data, m_data); end
    vectors++; if (bus.oerr !== m_oerr) begin miscompares++; $display("FAIL overrun_oerr got %b want %b", bus.oerr, m_oerr); end
    $display("overrun: 11 then 22 no ack oerr=%b", bus.oerr);
    pulse_ack();
    vectors++; if (bus.rda !== m_rda) begin miscompares++; $display("FAIL overrun_ack_rda got %b want %b", bus.rda, m_rda); end
    vectors++; if (bus.oerr !== m_oerr) begin miscompares++; $display("FAIL overrun_ack_oerr got %b want %b", bus.oerr, m_oerr); end
  endtask

  task automatic test_simultaneous();
    int t;
    drive_frame(8'h44, 1'b1, 0, 0, FULL, t);
    model_load(8'h44, 1'b1, 1'b0);
    drive_frame(8'h33, 1'b1, LOAD_TK, 0, FULL, t);
    model_load(8'h33, 1'b1, 1'b1);
    vectors++; if (bus.rda !== m_rda) begin miscompares++; $display("FAIL simul_rda got %b want %b", bus.rda, m_rda); end
    vectors++; if (bus.data !== m_data) begin miscompares++; $display("FAIL simul_data got %h want %h", bus.data, m_data); end
    vectors++; if (bus.oerr !== m_oerr) begin miscompares++; $display("FAIL simul_oerr got %b want %b", bus.oerr, m_oerr); end
    $display("simultaneous: ack on load of 33 rda=%b oerr=%b", bus.rda, bus.oerr);
    pulse_ack();
  endtask

  task automatic test_random();
    int t;
    logic [7:0] b;
    logic stop, ack;
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      ack  = ($urandom_range(0, 3) == 0);
      drive_frame(b, stop, ack ? LOAD_TK : 0, 0, FULL, t);
      model_load(b, stop, ack);
      vectors++; if (bus.data !== m_data) begin miscompares++; $display("FAIL random_data got %h want %h", bus.data, m_data); end
      vectors++; if (bus.rda !== m_rda) begin miscompares++; $display("FAIL random_rda got %b want %b", bus.rda, m_rda); end
      vectors++; if (bus.ferr !== m_ferr) begin miscompares++; $display("FAIL random_ferr got %b want %b", bus.ferr, m_ferr); end
      vectors++; if (bus.oerr !== m_oerr) begin miscompares++; $display("FAIL random_oerr got %b want %b", bus.oerr, m_oerr); end
      $display("random: byte %h stop %b ack_at_load %b -> data=%h ferr=%b oerr=%b", b, stop, ack, bus.data, bus.ferr, bus.oerr);
      if ($urandom_range(0, 1) == 1) pulse_ack();
      repeat ($urandom_range(0, 5)) wait_tick();
    end
    pulse_ack();
  endtask

  task automatic test_async_reset();
    int t;
    drive_frame(8'hC3, 1'b1, 0, 0, FULL, t);
    model_load(8'hC3, 1'b1, 1'b0);
    drive_frame(8'h7E, 1'b0, 0, 0, FULL, t);
    model_load(8'h7E, 1'b0, 1'b0);
    drive_frame(8'h96, 1'b1, 0, 0, 60, t);
    #2 rst = 1'b0;
    m_data = 8'h00; m_rda = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
    #1;
    vectors++; if (bus.data !== m_data) begin miscompares++; $display("FAIL async_rst_data got %h want %h", bus.data, m_data); end
    vectors++; if (bus.rda !== m_rda) begin miscompares++; $display("FAIL async_rst_rda got %b want %b", bus.rda, m_rda); end
    vectors++; if (bus.ferr !== m_ferr) begin miscompares++; $display("FAIL async_rst_ferr got %b want %b", bus.ferr, m_ferr); end
    vectors++; if (bus.oerr !== m_oerr) begin miscompares++; $display("FAIL async_rst_oerr got %b want %b", bus.oerr, m_oerr); end
    $display("async_reset: asserted mid-frame, outputs data=%h rda=%b", bus.data, bus.rda);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (3) wait_tick();
    drive_frame(8'h5A, 1'b1, 0, 0, FULL, t);
    model_load(8'h5A, 1'b1, 1'b0);
    vectors++; if (bus.data !== m_data) begin miscompares++; $display("FAIL post_rst_data got %h want %h", bus.data, m_data); end
    vectors++; if (bus.rda !== m_rda) begin miscompares++; $display("FAIL post_rst_rda got %b want %b", bus.rda, m_rda); end
    vectors++; if (bus.ferr !== m_ferr) begin miscompares++; $display("FAIL post_rst_ferr got %b want %b", bus.ferr, m_ferr); end
    vectors++; if (bus.oerr !== m_oerr) begin miscompares++; $display("FAIL post_rst_oerr got %b want %b", bus.oerr, m_oerr); end
    $display("async_reset: byte 5A after release data=%h", bus.data);
    pulse_ack();
  endtask

`ifdef RX_MAJORITY_VOTE_EN
  task automatic test_glitch();
    int t;
    // Bit 3 is sampled at tick 8 + 16*4 + 1 relative to the falling edge.
    drive_frame(8'hFF, 1'b1, 0, OS / 2 + 4 * OS + 1, FULL, t);
    model_load(8'hFF, 1'b1, 1'b0);
    vectors++; if (bus.data !== m_data) begin miscompares++; $display("FAIL glitch_data got %h want %h", bus.data, m_data); end
    $display("glitch: one-tick low in bit 3 of FF data=%h", bus.data);
    pulse_ack();
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_data = 8'h00; m_rda = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
    rst        = 1'b0;
    rxd        = 1'b1;
    bus.rd_ack = 1'b0;

    test_reset();
    test_nominal();
    test_false_start();
    test_framing();
    test_overrun();
    test_simultaneous();
    test_random();
    test_async_reset();
`ifdef RX_MAJORITY_VOTE_EN
    test_glitch();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
